// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers and direction encodings.
//   b2g(bin)  : binary -> Gray, bin ^ (bin >> 1)
//   g2b(gray) : Gray -> binary, prefix XOR from the MSB
// Both functions operate on GRAY_MAX_W-bit vectors. Callers zero-extend their
// N-bit value in and cast the result back to N bits. Zero-extended upper bits
// do not disturb the lower bits of either transform.
package gray_pkg;

   localparam int GRAY_MAX_W = 32;

   // up_dn encodings
   localparam logic UP   = 1'b1;
   localparam logic DOWN = 1'b0;

   function automatic logic [GRAY_MAX_W-1:0] b2g(input logic [GRAY_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] g2b(input logic [GRAY_MAX_W-1:0] gray);
      logic [GRAY_MAX_W-1:0] bin;
      bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_to_bin.sv
// gray_to_bin: combinational Gray -> binary decoder (prefix XOR from the MSB).
// Ports:
//   gray : N-bit Gray-coded input
//   bin  : N-bit binary equivalent
// This block is also suitable for decoding synchronised FIFO pointers.
module gray_to_bin
   import gray_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] gray,
   output logic [N-1:0] bin
);

   assign bin = N'(g2b(GRAY_MAX_W'(gray)));

endmodule

// File: rtl/gray_counter.sv
// gray_counter: up/down counter that keeps registered binary and Gray count
// values in step. It supports a parallel load of either encoding, wrap or
// saturate at the limits, and terminal-count status.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   en            : count enable, one step per cycle
//   up_dn         : 1 = up, 0 = down
//   load          : synchronous parallel load, has priority over en
//   load_is_gray  : load_val is Gray-coded (1) or binary (0)
//   load_val      : value to load
//   count_bin     : registered binary count
//   count_gray    : registered Gray count, always b2g(count_bin)
//   tc            : terminal count for the current direction (combinational)
//   wrapped       : one-cycle pulse after a wrap-around step
//   saturated     : high while a step is blocked at a limit (WRAP=0)
module gray_counter
   import gray_pkg::*;
#(
   parameter int N    = 4,
   parameter bit WRAP = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         up_dn,
   input  logic         load,
   input  logic         load_is_gray,
   input  logic [N-1:0] load_val,
   output logic [N-1:0] count_bin,
   output logic [N-1:0] count_gray,
   output logic         tc,
   output logic         wrapped,
   output logic         saturated
);

   generate
      if (N < 2) begin : g_bad_n
         $fatal(1, "gray_counter: N must be >= 2");
      end
      if (N > GRAY_MAX_W) begin : g_wide_n
         $fatal(1, "gray_counter: N exceeds GRAY_MAX_W");
      end
   endgenerate

   localparam logic [N-1:0] MAX_VAL = '1;
   localparam logic [N-1:0] MIN_VAL = '0;

   logic [N-1:0] bin_q,  bin_d;
   logic [N-1:0] gray_q, gray_d;
   logic         wrapped_q, wrapped_d;
   logic         sat_q, sat_d;
   logic [N-1:0] load_bin;

   gray_to_bin #(.N(N)) u_g2b (
      .gray (load_val),
      .bin  (load_bin)
   );

   always_comb begin
      bin_d     = bin_q;
      wrapped_d = 1'b0;
      sat_d     = 1'b0;
      if (load) begin
         bin_d = load_is_gray ? load_bin : load_val;
      end else if (en) begin
         if (up_dn == UP) begin
            if (bin_q != MAX_VAL) begin
               bin_d = bin_q + 1'b1;
            end else if (WRAP) begin
               bin_d     = MIN_VAL;
               wrapped_d = 1'b1;
            end else begin
               sat_d = 1'b1;
            end
         end else begin
            if (bin_q != MIN_VAL) begin
               bin_d = bin_q - 1'b1;
            end else if (WRAP) begin
               bin_d     = MAX_VAL;
               wrapped_d = 1'b1;
            end else begin
               sat_d = 1'b1;
            end
         end
      end
   end

   // The Gray output is registered from the next binary value. This keeps the
   // output flop-driven and glitch-free for capture in other domains.
   assign gray_d = N'(b2g(GRAY_MAX_W'(bin_d)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q     <= '0;
         gray_q    <= '0;
         wrapped_q <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         bin_q     <= bin_d;
         gray_q    <= gray_d;
         wrapped_q <= wrapped_d;
         sat_q     <= sat_d;
      end
   end

   assign count_bin  = bin_q;
   assign count_gray = gray_q;
   assign wrapped    = wrapped_q;
   assign saturated  = sat_q;
   assign tc         = (up_dn == UP) ? (bin_q == MAX_VAL) : (bin_q == MIN_VAL);

endmodule
